// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and constants for the fabric (crossbar and slaves).
package axi_lite_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_wr_join.sv
// AXI4-Lite write-side join: independent AW and W holding slots plus the
// collect/respond FSM. Emits a one-cycle commit strobe with the joined
// address, data and strobes; the owner reports whether that commit errors.
module axi_lite_wr_join
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic [STRB_W-1:0] w_strb,
  input  logic              w_valid,
  output logic              w_ready,
  output resp_t             b_resp,
  output logic              b_valid,
  input  logic              b_ready,
  output logic              commit,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [DATA_W-1:0] commit_data,
  output logic [STRB_W-1:0] commit_strb,
  input  logic              commit_err
);

  typedef enum logic [0:0] {WCollect, WResp} wr_state_e;

  wr_state_e         state_q, state_d;
  logic              aw_full_q, aw_full_d;
  logic              w_full_q, w_full_d;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  resp_t             b_resp_q, b_resp_d;

  // Slots accept whenever empty, so readiness is purely a function of state.
  assign aw_ready    = !aw_full_q;
  assign w_ready     = !w_full_q;
  assign b_valid     = (state_q == WResp);
  assign b_resp      = b_resp_q;
  assign commit_addr = aw_addr_q;
  assign commit_data = w_data_q;
  assign commit_strb = w_strb_q;

  // Next-state: fill slots, commit once both are full and no response is pending.
  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    b_resp_d  = b_resp_q;
    commit    = 1'b0;
    if (aw_valid && !aw_full_q) aw_full_d = 1'b1;
    if (w_valid && !w_full_q) w_full_d = 1'b1;
    case (state_q)
      WCollect: begin
        if (aw_full_q && w_full_q) begin
          commit    = 1'b1;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          b_resp_d  = commit_err ? RESP_SLVERR : RESP_OKAY;
          state_d   = WResp;
        end
      end
      WResp: begin
        if (b_ready) state_d = WCollect;
      end
      default: state_d = WCollect;
    endcase
  end

  // State, slot flags and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WCollect;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      b_resp_q  <= b_resp_d;
    end
  end

  // Slot payload capture on each channel's handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_valid && !aw_full_q) aw_addr_q <= aw_addr;
      if (w_valid && !w_full_q) begin
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
    end
  end

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite register bank: NUM_REGS 32-bit registers, each R/W control or
// read-only status, with parallel register outputs and per-register write pulses.
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int unsigned       NUM_REGS  = 8,
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [63:0]       RO_MASK   = 64'h0,
  parameter logic [DATA_W-1:0] RESET_VAL = 32'h0
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic [2:0]                 AWPROT,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [STRB_W-1:0]          WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output resp_t                      BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  input  logic [2:0]                 ARPROT,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_W-1:0]          RDATA,
  output resp_t                      RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr_pulse,
  input  logic [NUM_REGS*DATA_W-1:0] status_d
);

  logic              commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [31:0]       wr_idx, rd_idx;
  logic              wr_err, rd_in_range;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  resp_t             rresp_q;
  logic              unused_bits;

  // Protection and sub-word address bits carry no meaning here.
  assign unused_bits = ^{AWPROT, ARPROT, wr_addr[1:0], ARADDR[1:0]};

  axi_lite_wr_join #(
    .ADDR_W (ADDR_W)
  ) u_wr_join (
    .clk         (ACLK),
    .rst         (ARESET),
    .aw_addr     (AWADDR),
    .aw_valid    (AWVALID),
    .aw_ready    (AWREADY),
    .w_data      (WDATA),
    .w_strb      (WSTRB),
    .w_valid     (WVALID),
    .w_ready     (WREADY),
    .b_resp      (BRESP),
    .b_valid     (BVALID),
    .b_ready     (BREADY),
    .commit      (commit),
    .commit_addr (wr_addr),
    .commit_data (wr_data),
    .commit_strb (wr_strb),
    .commit_err  (wr_err)
  );

  // Word index decode; NUM_REGS <= 64 so the low six bits select the RO mask bit.
  assign wr_idx      = 32'(wr_addr[ADDR_W-1:2]);
  assign rd_idx      = 32'(ARADDR[ADDR_W-1:2]);
  assign wr_err      = (wr_idx >= NUM_REGS) || RO_MASK[wr_idx[5:0]];
  assign rd_in_range = (rd_idx < NUM_REGS);

  // One-hot write pulse for the committed R/W register, even with WSTRB == 0.
  always_comb begin
    reg_wr_pulse = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit && !wr_err && (wr_idx == 32'(i))) reg_wr_pulse[i] = 1'b1;
    end
  end

  // Register array with byte-lane write enables.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int k = 0; k < STRB_W; k++) begin
          if (reg_wr_pulse[i] && wr_strb[k]) regs_q[i][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  // Flatten the array onto the parallel control output.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[DATA_W*i +: DATA_W] = regs_q[i];
  end

  // Read mux: status input for RO registers, stored value otherwise, zero if out of range.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == 32'(i)) begin
        rd_val = RO_MASK[i] ? status_d[DATA_W*i +: DATA_W] : regs_q[i];
      end
    end
  end

  // Read response register; data is captured with the AR handshake and held until R handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ARVALID && !rvalid_q) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_val;
      rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign ARREADY = !rvalid_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Self-checking bench for axi_lite_reg_bank (8 registers, register 1 read-only).
module tb_axi_lite_reg_bank;
  import axi_lite_pkg::*;

  localparam int unsigned NumRegs = 8;
  localparam int unsigned AddrW   = 12;
  localparam int          Timeout = 50;

  logic                      ACLK = 1'b0;
  logic                      ARESET = 1'b1;
  logic [AddrW-1:0]          AWADDR = '0;
  logic [2:0]                AWPROT = '0;
  logic                      AWVALID = 1'b0;
  logic                      AWREADY;
  logic [31:0]               WDATA = '0;
  logic [3:0]                WSTRB = '0;
  logic                      WVALID = 1'b0;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY = 1'b0;
  logic [AddrW-1:0]          ARADDR = '0;
  logic [2:0]                ARPROT = '0;
  logic                      ARVALID = 1'b0;
  logic                      ARREADY;
  logic [31:0]               RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY = 1'b0;
  logic [NumRegs*32-1:0]     reg_q;
  logic [NumRegs-1:0]        reg_wr_pulse;
  logic [NumRegs*32-1:0]     status_d = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt [NumRegs];
  logic [1:0]  b_exp_q [$];
  logic [33:0] r_exp_q [$];  // {resp, data}

  axi_lite_reg_bank #(
    .NUM_REGS  (NumRegs),
    .ADDR_W    (AddrW),
    .RO_MASK   (64'h2),
    .RESET_VAL (32'h0)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .AWADDR       (AWADDR),
    .AWPROT       (AWPROT),
    .AWVALID      (AWVALID),
    .AWREADY      (AWREADY),
    .WDATA        (WDATA),
    .WSTRB        (WSTRB),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .BRESP        (BRESP),
    .BVALID       (BVALID),
    .BREADY       (BREADY),
    .ARADDR       (ARADDR),
    .ARPROT       (ARPROT),
    .ARVALID      (ARVALID),
    .ARREADY      (ARREADY),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse),
    .status_d     (status_d)
  );

  always #5 ACLK = ~ACLK;

  // Count every write pulse seen at a clock edge.
  always @(posedge ACLK) begin
    for (int i = 0; i < NumRegs; i++) begin
      if (reg_wr_pulse[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
    end
  end

  function automatic int total_pulses();
    int s = 0;
    for (int i = 0; i < NumRegs; i++) s += pulse_cnt[i];
    return s;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge ACLK);
  endtask

  task automatic send_aw(input logic [AddrW-1:0] addr, output bit ok);
    ok = 1'b0;
    AWADDR = addr;
    AWVALID = 1'b1;
    for (int i = 0; i < Timeout && !ok; i++) begin
      if (AWREADY) ok = 1'b1;
      @(negedge ACLK);
    end
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, output bit ok);
    ok = 1'b0;
    WDATA = data;
    WSTRB = strb;
    WVALID = 1'b1;
    for (int i = 0; i < Timeout && !ok; i++) begin
      if (WREADY) ok = 1'b1;
      @(negedge ACLK);
    end
    WVALID = 1'b0;
  endtask

  // AW and W presented together; returns in the cycle after the later handshake.
  task automatic issue_write(input logic [AddrW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output bit ok);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    AWADDR = addr;
    AWVALID = 1'b1;
    WDATA = data;
    WSTRB = strb;
    WVALID = 1'b1;
    for (int i = 0; i < Timeout && !(aw_done && w_done); i++) begin
      if (AWVALID && AWREADY) aw_done = 1'b1;
      if (WVALID && WREADY) w_done = 1'b1;
      @(negedge ACLK);
      if (aw_done) AWVALID = 1'b0;
      if (w_done) WVALID = 1'b0;
    end
    AWVALID = 1'b0;
    WVALID = 1'b0;
    ok = aw_done && w_done;
  endtask

  task automatic collect_b(output logic [1:0] resp, output bit ok);
    ok = 1'b0;
    resp = 2'bxx;
    for (int i = 0; i < Timeout && !ok; i++) begin
      if (BVALID) begin
        ok = 1'b1;
        resp = BRESP;
        BREADY = 1'b1;
      end
      @(negedge ACLK);
    end
    BREADY = 1'b0;
  endtask

  task automatic collect_r(output logic [33:0] got, output bit ok);
    ok = 1'b0;
    got = 'x;
    for (int i = 0; i < Timeout && !ok; i++) begin
      if (RVALID) begin
        ok = 1'b1;
        got = {RRESP, RDATA};
        RREADY = 1'b1;
      end
      @(negedge ACLK);
    end
    RREADY = 1'b0;
  endtask

  task automatic do_read(input logic [AddrW-1:0] addr, output logic [33:0] got, output bit ok);
    bit ar_ok = 1'b0;
    ok = 1'b0;
    got = 'x;
    ARADDR = addr;
    ARVALID = 1'b1;
    for (int i = 0; i < Timeout && !ar_ok; i++) begin
      if (ARREADY) ar_ok = 1'b1;
      @(negedge ACLK);
    end
    ARVALID = 1'b0;
    if (ar_ok) collect_r(got, ok);
  endtask

  task automatic test_reset();
    logic [33:0] got, exp;
    bit ok;
    ARESET = 1'b1;
    tick(3);
    ARESET = 1'b0;
    tick(1);
    n_tests++; if (reg_q !== '0) begin n_fail++; $display("FAIL reset_reg_q: got %h, expected 0", reg_q); end
    n_tests++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin n_fail++;
      $display("FAIL reset_ready: got %b, expected 111", {AWREADY, WREADY, ARREADY}); end
    n_tests++; if ({BVALID, RVALID} !== 2'b00) begin n_fail++;
      $display("FAIL reset_valid: got %b, expected 00", {BVALID, RVALID}); end
    n_tests++; if ({RDATA, RRESP, BRESP, reg_wr_pulse} !== '0) begin n_fail++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b, expected zeros", RDATA, RRESP, BRESP, reg_wr_pulse); end
    r_exp_q.push_back({RESP_OKAY, 32'h0});
    do_read(12'h004, got, ok);
    exp = r_exp_q.pop_front();
    n_tests++; if (!ok || got !== exp) begin n_fail++;
      $display("FAIL reset_read: got %h (ok=%0d), expected %h", got, ok, exp); end
  endtask

  task automatic test_write_strobe();
    logic [1:0] resp, exp;
    bit ok_w, ok_aw, ok_b;
    b_exp_q.push_back(RESP_OKAY);
    send_w(32'hDEADBEEF, 4'b0101, ok_w);
    tick(2);
    send_aw(12'h008, ok_aw);
    // Now in the commit cycle.
    n_tests++; if (!ok_w || !ok_aw || reg_wr_pulse !== 8'b0000_0100 || BVALID !== 1'b0) begin n_fail++;
      $display("FAIL strobe_commit_cycle: got pulse=%b bvalid=%b ok=%0d%0d, expected 00000100 0 11",
               reg_wr_pulse, BVALID, ok_w, ok_aw); end
    tick(1);
    n_tests++; if (BVALID !== 1'b1 || reg_wr_pulse !== '0) begin n_fail++;
      $display("FAIL strobe_bvalid_latency: got bvalid=%b pulse=%b, expected 1 00000000", BVALID, reg_wr_pulse); end
    n_tests++; if (reg_q[95:64] !== 32'h00AD00EF) begin n_fail++;
      $display("FAIL strobe_reg2: got %h, expected 00ad00ef", reg_q[95:64]); end
    n_tests++; if (pulse_cnt[2] != 1) begin n_fail++;
      $display("FAIL strobe_pulse_count: got %0d, expected 1", pulse_cnt[2]); end
    collect_b(resp, ok_b);
    exp = b_exp_q.pop_front();
    n_tests++; if (!ok_b || resp !== exp) begin n_fail++;
      $display("FAIL strobe_bresp: got %b (ok=%0d), expected %b", resp, ok_b, exp); end
  endtask

  task automatic test_ro();
    logic [1:0] resp, bexp;
    logic [33:0] got, rexp;
    bit ok, okb;
    int p0;
    status_d[63:32] = 32'h12345678;
    p0 = total_pulses();
    b_exp_q.push_back(RESP_SLVERR);
    issue_write(12'h004, 32'hFFFFFFFF, 4'hF, ok);
    collect_b(resp, okb);
    bexp = b_exp_q.pop_front();
    n_tests++; if (!ok || !okb || resp !== bexp) begin n_fail++;
      $display("FAIL ro_bresp: got %b (ok=%0d%0d), expected %b", resp, ok, okb, bexp); end
    n_tests++; if (total_pulses() != p0 || reg_q[63:32] !== 32'h0) begin n_fail++;
      $display("FAIL ro_no_effect: got pulses=%0d reg1=%h, expected %0d 00000000",
               total_pulses(), reg_q[63:32], p0); end
    r_exp_q.push_back({RESP_OKAY, 32'h12345678});
    do_read(12'h004, got, ok);
    rexp = r_exp_q.pop_front();
    n_tests++; if (!ok || got !== rexp) begin n_fail++;
      $display("FAIL ro_read: got %h (ok=%0d), expected %h", got, ok, rexp); end
  endtask

  task automatic test_out_of_range();
    logic [NumRegs*32-1:0] snap;
    logic [1:0] resp, bexp;
    logic [33:0] got, rexp;
    bit ok, okb;
    int p0;
    snap = reg_q;
    p0 = total_pulses();
    b_exp_q.push_back(RESP_SLVERR);
    issue_write(12'h040, 32'hCAFEF00D, 4'hF, ok);
    collect_b(resp, okb);
    bexp = b_exp_q.pop_front();
    n_tests++; if (!ok || !okb || resp !== bexp) begin n_fail++;
      $display("FAIL oor_bresp: got %b (ok=%0d%0d), expected %b", resp, ok, okb, bexp); end
    r_exp_q.push_back({RESP_SLVERR, 32'h0});
    do_read(12'h040, got, ok);
    rexp = r_exp_q.pop_front();
    n_tests++; if (!ok || got !== rexp) begin n_fail++;
      $display("FAIL oor_read: got %h (ok=%0d), expected %h", got, ok, rexp); end
    n_tests++; if (reg_q !== snap || total_pulses() != p0) begin n_fail++;
      $display("FAIL oor_no_effect: got %h pulses=%0d, expected %h pulses=%0d", reg_q, total_pulses(), snap, p0); end
  endtask

  task automatic test_bready_stall();
    logic [1:0] resp, bexp;
    bit ok1, ok2, okb;
    int p4;
    b_exp_q.push_back(RESP_OKAY);
    b_exp_q.push_back(RESP_OKAY);
    issue_write(12'h00C, 32'h11111111, 4'hF, ok1);
    tick(1);
    n_tests++; if (!ok1 || BVALID !== 1'b1) begin n_fail++;
      $display("FAIL stall_first_bvalid: got %b (ok=%0d), expected 1", BVALID, ok1); end
    p4 = pulse_cnt[4];
    issue_write(12'h010, 32'h22222222, 4'hF, ok2);
    n_tests++; if (!ok2 || {AWREADY, WREADY} !== 2'b00) begin n_fail++;
      $display("FAIL stall_slots_full: got %b (ok=%0d), expected 00", {AWREADY, WREADY}, ok2); end
    for (int c = 0; c < 5; c++) begin
      n_tests++; if ({BVALID, BRESP} !== 3'b100) begin n_fail++;
        $display("FAIL stall_b_hold[%0d]: got %b, expected 100", c, {BVALID, BRESP}); end
      n_tests++; if (reg_q[159:128] !== 32'h0 || pulse_cnt[4] != p4) begin n_fail++;
        $display("FAIL stall_no_commit[%0d]: got reg4=%h pulses=%0d, expected 0 %0d",
                 c, reg_q[159:128], pulse_cnt[4], p4); end
      tick(1);
    end
    collect_b(resp, okb);
    bexp = b_exp_q.pop_front();
    n_tests++; if (!okb || resp !== bexp) begin n_fail++;
      $display("FAIL stall_first_bresp: got %b (ok=%0d), expected %b", resp, okb, bexp); end
    n_tests++; if (reg_wr_pulse !== 8'b0001_0000) begin n_fail++;
      $display("FAIL stall_second_commit: got %b, expected 00010000", reg_wr_pulse); end
    collect_b(resp, okb);
    bexp = b_exp_q.pop_front();
    n_tests++; if (!okb || resp !== bexp) begin n_fail++;
      $display("FAIL stall_second_bresp: got %b (ok=%0d), expected %b", resp, okb, bexp); end
    n_tests++; if (reg_q[159:96] !== 64'h22222222_11111111) begin n_fail++;
      $display("FAIL stall_regs: got %h, expected 2222222211111111", reg_q[159:96]); end
  endtask

  task automatic test_back_to_back_collision();
    logic [1:0] resp, bexp;
    logic [33:0] got, rexp;
    bit ok, okb, okr;
    b_exp_q.push_back(RESP_OKAY);
    issue_write(12'h000, 32'h1, 4'hF, ok);
    collect_b(resp, okb);
    bexp = b_exp_q.pop_front();
    n_tests++; if (!ok || !okb || resp !== bexp) begin n_fail++;
      $display("FAIL coll_first_bresp: got %b (ok=%0d%0d), expected %b", resp, ok, okb, bexp); end
    b_exp_q.push_back(RESP_OKAY);
    r_exp_q.push_back({RESP_OKAY, 32'h1});
    issue_write(12'h000, 32'h2, 4'hF, ok);
    // Commit cycle: present AR so both land on the same edge.
    ARADDR = 12'h000;
    ARVALID = 1'b1;
    n_tests++; if (!ok || reg_wr_pulse[0] !== 1'b1 || ARREADY !== 1'b1) begin n_fail++;
      $display("FAIL coll_alignment: got pulse0=%b arready=%b ok=%0d, expected 1 1 1",
               reg_wr_pulse[0], ARREADY, ok); end
    tick(1);
    ARVALID = 1'b0;
    collect_r(got, okr);
    rexp = r_exp_q.pop_front();
    n_tests++; if (!okr || got !== rexp) begin n_fail++;
      $display("FAIL coll_read_old: got %h (ok=%0d), expected %h", got, okr, rexp); end
    collect_b(resp, okb);
    bexp = b_exp_q.pop_front();
    n_tests++; if (!okb || resp !== bexp) begin n_fail++;
      $display("FAIL coll_second_bresp: got %b (ok=%0d), expected %b", resp, okb, bexp); end
    r_exp_q.push_back({RESP_OKAY, 32'h2});
    do_read(12'h000, got, okr);
    rexp = r_exp_q.pop_front();
    n_tests++; if (!okr || got !== rexp) begin n_fail++;
      $display("FAIL coll_read_new: got %h (ok=%0d), expected %h", got, okr, rexp); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp, bexp;
    bit ok, okb;
    int p0;
    ARADDR = 12'h008;
    ARVALID = 1'b1;
    tick(1);
    ARVALID = 1'b0;
    n_tests++; if (RVALID !== 1'b1) begin n_fail++;
      $display("FAIL mid_rvalid_before: got %b, expected 1", RVALID); end
    send_aw(12'h014, ok);
    n_tests++; if (!ok || AWREADY !== 1'b0) begin n_fail++;
      $display("FAIL mid_aw_slot: got awready=%b (ok=%0d), expected 0", AWREADY, ok); end
    #2 ARESET = 1'b1;
    #1;
    n_tests++; if ({RVALID, AWREADY} !== 2'b01) begin n_fail++;
      $display("FAIL mid_async_clear: got rvalid,awready=%b, expected 01", {RVALID, AWREADY}); end
    n_tests++; if (reg_q !== '0) begin n_fail++;
      $display("FAIL mid_regs_cleared: got %h, expected 0", reg_q); end
    tick(2);
    ARESET = 1'b0;
    tick(1);
    p0 = total_pulses();
    send_w(32'h00000055, 4'hF, ok);
    tick(3);
    n_tests++; if (!ok || BVALID !== 1'b0 || total_pulses() != p0) begin n_fail++;
      $display("FAIL mid_stale_aw_dropped: got bvalid=%b pulses=%0d (ok=%0d), expected 0 %0d",
               BVALID, total_pulses(), ok, p0); end
    b_exp_q.push_back(RESP_OKAY);
    send_aw(12'h014, ok);
    collect_b(resp, okb);
    bexp = b_exp_q.pop_front();
    n_tests++; if (!ok || !okb || resp !== bexp || reg_q[191:160] !== 32'h55) begin n_fail++;
      $display("FAIL mid_reissue: got bresp=%b reg5=%h (ok=%0d%0d), expected %b 00000055",
               resp, reg_q[191:160], ok, okb, bexp); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, expected earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_strobe();
    test_ro();
    test_out_of_range();
    test_bready_stall();
    test_back_to_back_collision();
    test_reset_mid();
    n_tests++; if (b_exp_q.size() != 0 || r_exp_q.size() != 0) begin n_fail++;
      $display("FAIL scoreboard_drained: got %0d/%0d entries left, expected 0/0",
               b_exp_q.size(), r_exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
